// File: rtl/cpu_core_stacked_pkg.sv
`default_nettype none
// ============================================================================
// Module : cpu_core_stacked_pkg
// Brief  : Shared encodings for the stacked core: groups, commands, states,
//          flag bit positions and instruction field offsets.
// Rev    : 1.0
// ============================================================================
package cpu_core_stacked_pkg;

  localparam logic [2:0] GRP_ARITH  = 3'd0;
  localparam logic [2:0] GRP_LOGIC  = 3'd1;
  localparam logic [2:0] GRP_SHIFT  = 3'd2;
  localparam logic [2:0] GRP_MOVE   = 3'd3;
  localparam logic [2:0] GRP_OUT    = 3'd4;
  localparam logic [2:0] GRP_JUMP   = 3'd5;
  localparam logic [2:0] GRP_BRANCH = 3'd6;
  localparam logic [2:0] GRP_FLOW   = 3'd7;

  localparam logic [2:0] CMD_SUB  = 3'd1;
  localparam logic [2:0] CMD_AND  = 3'd0;
  localparam logic [2:0] CMD_OR   = 3'd1;
  localparam logic [2:0] CMD_XOR  = 3'd2;
  localparam logic [2:0] CMD_CALL = 3'd0;
  localparam logic [2:0] CMD_RET  = 3'd1;
  localparam logic [2:0] CMD_HALT = 3'd2;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  // Indices into the upper flag nibble (reg_flag[7:4])
  localparam int FLAG_ARITH_OVF = 0;
  localparam int FLAG_SHIFT_OVF = 1;
  localparam int FLAG_STACK_OVF = 2;
  localparam int FLAG_STACK_UNF = 3;

  // Register operand map: 0xFF reads din, anything else aliases onto 16 GPRs
  localparam int         NUM_REGS = 16;
  localparam logic [7:0] REG_DIN  = 8'hFF;

  function automatic int f_off_arg2(input int addr_w);      return addr_w;      endfunction
  function automatic int f_off_arg2_type(input int addr_w); return addr_w + 8;  endfunction
  function automatic int f_off_arg1(input int addr_w);      return addr_w + 9;  endfunction
  function automatic int f_off_arg1_type(input int addr_w); return addr_w + 17; endfunction
  function automatic int f_off_cmd(input int addr_w);       return addr_w + 18; endfunction
  function automatic int f_off_grp(input int addr_w);       return addr_w + 21; endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_core_stacked_call_stack.sv
`default_nettype none
// ============================================================================
// Module : cpu_core_stacked_call_stack
// Brief  : Return-address LIFO; synchronous push/pop, combinational top.
// Rev    : 1.0
// ============================================================================
module cpu_core_stacked_call_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] top
);

  localparam int SP_W  = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [SP_W-1:0]  sp_q, sp_d;
  logic [WIDTH-1:0] mem_q [2**IDX_W];
  logic [IDX_W-1:0] wr_idx, rd_idx;

  assign full   = (sp_q == SP_W'(DEPTH));
  assign empty  = (sp_q == '0);
  assign wr_idx = IDX_W'(sp_q);
  assign rd_idx = IDX_W'(sp_q - SP_W'(1));
  assign top    = mem_q[rd_idx];

  always_comb begin
    sp_d = sp_q;
    if (push && !full)       sp_d = sp_q + SP_W'(1);
    else if (pop && !empty)  sp_d = sp_q - SP_W'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) sp_q <= '0;
    else         sp_q <= sp_d;
  end

  // Entries above sp are don't-care, so the storage needs no reset
  always_ff @(posedge clk) begin
    if (push && !full) mem_q[wr_idx] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/cpu_core_stacked.sv
`default_nettype none
// ============================================================================
// Module : cpu_core_stacked
// Brief  : Parametrised single-cycle core with call stack, HALT and FAULT lock.
//          Optional: define CPU_SINGLE_STEP_EN to add the step input.
// Rev    : 1.0
// ============================================================================
module cpu_core_stacked
  import cpu_core_stacked_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                enable,
  input  logic [24+ADDR_W-1:0] instruction,
  output logic [ADDR_W-1:0]   instruction_pointer,
  input  logic [DATA_W-1:0]   din,
  input  logic [3:0]          gpi,
  input  logic                resume,
`ifdef CPU_SINGLE_STEP_EN
  input  logic                step,
`endif
  output logic [DATA_W-1:0]   reg_dout,
  output logic [DATA_W-1:0]   reg_gout,
  output logic [7:0]          reg_flag,
  output logic                halted,
  output logic                fault
);

  localparam int OFF_GRP  = f_off_grp(ADDR_W);
  localparam int OFF_CMD  = f_off_cmd(ADDR_W);
  localparam int OFF_A1T  = f_off_arg1_type(ADDR_W);
  localparam int OFF_A1   = f_off_arg1(ADDR_W);
  localparam int OFF_A2T  = f_off_arg2_type(ADDR_W);
  localparam int OFF_A2   = f_off_arg2(ADDR_W);
  localparam logic [DATA_W-1:0] SHIFT_LIM = DATA_W'(DATA_W);

  logic [2:0]        grp, cmd;
  logic              a1_is_reg, a2_is_reg;
  logic [7:0]        arg1, arg2;
  logic [ADDR_W-1:0] target;

  assign grp       = instruction[OFF_GRP +: 3];
  assign cmd       = instruction[OFF_CMD +: 3];
  assign a1_is_reg = instruction[OFF_A1T];
  assign arg1      = instruction[OFF_A1 +: 8];
  assign a2_is_reg = instruction[OFF_A2T];
  assign arg2      = instruction[OFF_A2 +: 8];
  assign target    = instruction[ADDR_W-1:0];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ip_q, ip_d, ip_inc;
  logic [DATA_W-1:0] dout_q, dout_d, gout_q, gout_d;
  logic [3:0]        flag_hi_q, flag_hi_d;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  logic [DATA_W-1:0]   op1, op2, alu_res;
  logic [DATA_W:0]     sum;
  logic [2*DATA_W-1:0] shl_wide;
  logic                alu_arith_ovf, alu_shift_ovf, br_taken;
  logic                step_req, exec;
  logic                stk_push, stk_pop, stk_full, stk_empty;
  logic [ADDR_W-1:0]   stk_top;

`ifdef CPU_SINGLE_STEP_EN
  assign step_req = step;
`else
  assign step_req = 1'b0;
`endif

  assign ip_inc              = ip_q + ADDR_W'(1);
  assign instruction_pointer = ip_q;
  assign reg_dout            = dout_q;
  assign reg_gout            = gout_q;
  assign reg_flag            = {flag_hi_q, gpi};
  assign halted              = (state_q == ST_HALT);
  assign fault               = (state_q == ST_FAULT);

  always_comb begin
    op1 = DATA_W'(arg1);
    op2 = DATA_W'(arg2);
    if (a1_is_reg) op1 = (arg1 == REG_DIN) ? din : regs_q[arg1[3:0]];
    if (a2_is_reg) op2 = (arg2 == REG_DIN) ? din : regs_q[arg2[3:0]];
  end

  always_comb begin
    sum           = '0;
    shl_wide      = '0;
    alu_res       = '0;
    alu_arith_ovf = 1'b0;
    alu_shift_ovf = 1'b0;
    case (grp)
      GRP_ARITH: begin
        sum = (cmd == CMD_SUB) ? ({1'b0, op1} - {1'b0, op2}) : ({1'b0, op1} + {1'b0, op2});
        alu_res       = sum[DATA_W-1:0];
        alu_arith_ovf = sum[DATA_W];
      end
      GRP_LOGIC: begin
        case (cmd)
          CMD_AND: alu_res = op1 & op2;
          CMD_OR:  alu_res = op1 | op2;
          CMD_XOR: alu_res = op1 ^ op2;
          default: alu_res = ~op1;
        endcase
      end
      GRP_SHIFT: begin
        if (cmd[0]) begin
          alu_res = op1 >> op2;
        end else begin
          // Upper half of the widened shift holds exactly the bits pushed out
          shl_wide      = {{DATA_W{1'b0}}, op1} << op2;
          alu_res       = shl_wide[DATA_W-1:0];
          alu_shift_ovf = (op2 >= SHIFT_LIM) ? (op1 != '0) : (shl_wide[2*DATA_W-1:DATA_W] != '0);
        end
      end
      GRP_BRANCH: alu_res = op1 & op2;
      default: ;
    endcase
  end

  assign br_taken = (alu_res != '0) || reg_flag[cmd];

  always_comb begin
    state_d   = state_q;
    ip_d      = ip_q;
    dout_d    = dout_q;
    gout_d    = gout_q;
    flag_hi_d = flag_hi_q;
    regs_d    = regs_q;
    stk_push  = 1'b0;
    stk_pop   = 1'b0;
    exec      = 1'b0;
    if (enable) begin
      case (state_q)
        ST_RUN:  exec = 1'b1;
        ST_HALT: if (resume) state_d = ST_RUN; else exec = step_req;
        default: ;
      endcase
    end
    if (exec) begin
      ip_d = ip_inc;
      case (grp)
        GRP_ARITH, GRP_LOGIC, GRP_SHIFT: begin
          regs_d[4'(target)]        = alu_res;
          flag_hi_d[FLAG_ARITH_OVF] = alu_arith_ovf;
          flag_hi_d[FLAG_SHIFT_OVF] = alu_shift_ovf;
        end
        GRP_MOVE:   regs_d[4'(target)] = op1;
        GRP_OUT:    if (cmd[0]) gout_d = op1; else dout_d = op1;
        GRP_JUMP:   ip_d = target;
        GRP_BRANCH: if (br_taken) ip_d = target;
        GRP_FLOW: begin
          case (cmd)
            CMD_CALL: begin
              if (stk_full) begin
                flag_hi_d[FLAG_STACK_OVF] = 1'b1;
                ip_d    = ip_q;
                state_d = ST_FAULT;
              end else begin
                stk_push = 1'b1;
                ip_d     = target;
              end
            end
            CMD_RET: begin
              if (stk_empty) begin
                flag_hi_d[FLAG_STACK_UNF] = 1'b1;
                ip_d    = ip_q;
                state_d = ST_FAULT;
              end else begin
                stk_pop = 1'b1;
                ip_d    = stk_top;
              end
            end
            CMD_HALT: state_d = ST_HALT;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_RUN;
      ip_q      <= '0;
      dout_q    <= '0;
      gout_q    <= '0;
      flag_hi_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      ip_q      <= ip_d;
      dout_q    <= dout_d;
      gout_q    <= gout_d;
      flag_hi_q <= flag_hi_d;
      regs_q    <= regs_d;
    end
  end

  cpu_core_stacked_call_stack #(
    .WIDTH (ADDR_W),
    .DEPTH (STACK_DEPTH)
  ) u_call_stack (
    .clk       (clk),
    .resetn    (resetn),
    .push      (stk_push),
    .pop       (stk_pop),
    .push_data (ip_inc),
    .full      (stk_full),
    .empty     (stk_empty),
    .top       (stk_top)
  );

endmodule
`default_nettype wire

// File: tb/tb_cpu_core_stacked.sv
`default_nettype none
// ============================================================================
// Module : tb_cpu_core_stacked
// Brief  : Directed and randomized checks of cpu_core_stacked against a
//          behavioural model (DATA_W=8, ADDR_W=8, STACK_DEPTH=4).
// Rev    : 1.0
// ============================================================================
module tb_cpu_core_stacked;

  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        enable = 1'b0;
  logic        resume = 1'b0;
  logic [31:0] instruction;
  logic [7:0]  instruction_pointer;
  logic [7:0]  din = '0;
  logic [3:0]  gpi = '0;
  logic [7:0]  reg_dout, reg_gout, reg_flag;
  logic        halted, fault;
`ifdef CPU_SINGLE_STEP_EN
  logic        step = 1'b0;
`endif

  logic [31:0] rom [256];
  assign instruction = rom[instruction_pointer];

  always #5 clk = ~clk;

  cpu_core_stacked #(
    .DATA_W      (8),
    .ADDR_W      (8),
    .STACK_DEPTH (SD)
  ) dut (
    .clk                 (clk),
    .resetn              (resetn),
    .enable              (enable),
    .instruction         (instruction),
    .instruction_pointer (instruction_pointer),
    .din                 (din),
    .gpi                 (gpi),
    .resume              (resume),
`ifdef CPU_SINGLE_STEP_EN
    .step                (step),
`endif
    .reg_dout            (reg_dout),
    .reg_gout            (reg_gout),
    .reg_flag            (reg_flag),
    .halted              (halted),
    .fault               (fault)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural model: mode 0 = running, 1 = halted, 2 = faulted
  int m_ip, m_mode, m_dout, m_gout;
  int m_ar, m_sh, m_ov, m_un;
  int m_regs [16];
  int m_stack [$];

  function automatic logic [31:0] enc(int g, int c, int t1, int a1, int t2, int a2, int ad);
    logic [31:0] r;
    r = 32'(g % 8);
    r = (r << 3) | 32'(c % 8);
    r = (r << 1) | 32'(t1 % 2);
    r = (r << 8) | 32'(a1 % 256);
    r = (r << 1) | 32'(t2 % 2);
    r = (r << 8) | 32'(a2 % 256);
    r = (r << 8) | 32'(ad % 256);
    return r;
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = enc(7, 3, 0, 0, 0, 0, 0);
  endtask

  task automatic model_reset();
    m_ip = 0; m_mode = 0; m_dout = 0; m_gout = 0;
    m_ar = 0; m_sh = 0; m_ov = 0; m_un = 0;
    for (int i = 0; i < 16; i++) m_regs[i] = 0;
    m_stack.delete();
  endtask

  task automatic model_step(input bit en, input bit res, input bit stp, input int dinv, input int gpiv);
    logic [31:0] ins;
    int g, c, a1, a2, ad, o1, o2, s, v, sh, nxt, fl;
    if (!en || m_mode == 2) return;
    if (m_mode == 1) begin
      if (res) begin m_mode = 0; return; end
      if (!stp) return;
    end
    ins = rom[m_ip];
    g  = int'(ins[31:29]); c  = int'(ins[28:26]);
    a1 = int'(ins[24:17]); a2 = int'(ins[15:8]); ad = int'(ins[7:0]);
    o1 = ins[25] ? ((a1 == 255) ? dinv : m_regs[a1 % 16]) : a1;
    o2 = ins[16] ? ((a2 == 255) ? dinv : m_regs[a2 % 16]) : a2;
    fl  = m_un * 128 + m_ov * 64 + m_sh * 32 + m_ar * 16 + gpiv;
    nxt = (m_ip + 1) % 256;
    case (g)
      0: begin
        s = (c == 1) ? o1 - o2 : o1 + o2;
        m_ar = (s < 0 || s > 255) ? 1 : 0; m_sh = 0;
        m_regs[ad % 16] = (s + 256) % 256; m_ip = nxt;
      end
      1: begin
        m_ar = 0; m_sh = 0;
        v = (c == 0) ? (o1 & o2) : (c == 1) ? (o1 | o2) : (c == 2) ? (o1 ^ o2) : 255 - o1;
        m_regs[ad % 16] = v; m_ip = nxt;
      end
      2: begin
        v = o1; sh = 0;
        if (c % 2 == 1) repeat (o2) v = v / 2;
        else repeat (o2) begin v = v * 2; if (v > 255) begin sh = 1; v = v - 256; end end
        m_ar = 0; m_sh = sh; m_regs[ad % 16] = v; m_ip = nxt;
      end
      3: begin m_regs[ad % 16] = o1; m_ip = nxt; end
      4: begin if (c % 2 == 1) m_gout = o1; else m_dout = o1; m_ip = nxt; end
      5: m_ip = ad;
      6: m_ip = (((o1 & o2) != 0) || (((fl >> c) & 1) == 1)) ? ad : nxt;
      default: begin
        if (c == 0) begin
          if (m_stack.size() >= SD) begin m_ov = 1; m_mode = 2; end
          else begin m_stack.push_back(nxt); m_ip = ad; end
        end else if (c == 1) begin
          if (m_stack.size() == 0) begin m_un = 1; m_mode = 2; end
          else m_ip = m_stack.pop_back();
        end else if (c == 2) begin
          m_ip = nxt; m_mode = 1;
        end else m_ip = nxt;
      end
    endcase
  endtask

  task automatic check_all();
    check_val("ip", instruction_pointer, m_ip);
    check_val("dout", reg_dout, m_dout);
    check_val("gout", reg_gout, m_gout);
    check_val("flag", reg_flag, m_un * 128 + m_ov * 64 + m_sh * 32 + m_ar * 16 + int'(gpi));
    check_val("halted", halted, (m_mode == 1) ? 1 : 0);
    check_val("fault", fault, (m_mode == 2) ? 1 : 0);
  endtask

  task automatic run_cycle(input bit en, input bit res, input bit stp, input int dinv, input int gpiv);
`ifndef CPU_SINGLE_STEP_EN
    stp = 1'b0;
`endif
    @(negedge clk);
    enable = en; resume = res; din = dinv[7:0]; gpi = gpiv[3:0];
`ifdef CPU_SINGLE_STEP_EN
    step = stp;
`endif
    model_step(en, res, stp, dinv, gpiv);
    @(posedge clk);
    #1;
    check_all();
  endtask

  // Reset is asserted between edges so the checks observe the asynchronous clear
  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    #2;
    check_val("rst_ip", instruction_pointer, 0);
    check_val("rst_dout", reg_dout, 0);
    check_val("rst_gout", reg_gout, 0);
    check_val("rst_flag_hi", reg_flag[7:4], 0);
    check_val("rst_halted", halted, 0);
    check_val("rst_fault", fault, 0);
    model_reset();
    @(negedge clk);
    enable = 1'b0; resume = 1'b0;
    resetn = 1'b1;
  endtask

  initial begin
    clear_rom();
    do_reset();

    for (int k = 1; k <= 3; k++) begin
      run_cycle(1, 0, 0, 0, 0);
      check_val("nop_ip", instruction_pointer, k);
    end

    do_reset();
    rom[0] = enc(0, 0, 0, 200, 0, 100, 1);
    rom[1] = enc(4, 0, 1, 1, 0, 0, 0);
    run_cycle(1, 0, 0, 0, 0);
    check_val("add_arith_ovf", reg_flag[4], 1);
    run_cycle(1, 0, 0, 0, 0);
    check_val("add_dout", reg_dout, 8'h2C);

    do_reset();
    clear_rom();
    rom[8'h00] = enc(5, 0, 0, 0, 0, 0, 8'h10);
    rom[8'h10] = enc(7, 0, 0, 0, 0, 0, 8'h40);
    rom[8'h40] = enc(7, 1, 0, 0, 0, 0, 0);
    rom[8'h11] = enc(7, 1, 0, 0, 0, 0, 0);
    run_cycle(1, 0, 0, 0, 0); check_val("call_ip0", instruction_pointer, 8'h10);
    run_cycle(1, 0, 0, 0, 0); check_val("call_ip1", instruction_pointer, 8'h40);
    run_cycle(1, 0, 0, 0, 0); check_val("ret_ip", instruction_pointer, 8'h11);
    run_cycle(1, 0, 0, 0, 0);
    check_val("unf_fault", fault, 1);
    check_val("unf_flag7", reg_flag[7], 1);
    check_val("unf_ip", instruction_pointer, 8'h11);

    do_reset();
    clear_rom();
    rom[8'h00] = enc(7, 0, 0, 0, 0, 0, 8'h20);
    rom[8'h20] = enc(7, 0, 0, 0, 0, 0, 8'h30);
    rom[8'h30] = enc(7, 0, 0, 0, 0, 0, 8'h40);
    rom[8'h40] = enc(7, 0, 0, 0, 0, 0, 8'h50);
    rom[8'h50] = enc(7, 0, 0, 0, 0, 0, 8'h60);
    for (int k = 0; k < 5; k++) run_cycle(1, 0, 0, 0, 0);
    check_val("ovf_fault", fault, 1);
    check_val("ovf_flag6", reg_flag[6], 1);
    check_val("ovf_ip", instruction_pointer, 8'h50);
    for (int k = 0; k < 3; k++) run_cycle(1, 1, 1, 0, 0);
    check_val("ovf_frozen_ip", instruction_pointer, 8'h50);

    do_reset();
    clear_rom();
    rom[8'h00] = enc(5, 0, 0, 0, 0, 0, 8'h05);
    rom[8'h05] = enc(7, 2, 0, 0, 0, 0, 0);
    run_cycle(1, 0, 0, 0, 0);
    run_cycle(1, 0, 0, 0, 0);
    check_val("halt_halted", halted, 1);
    check_val("halt_ip", instruction_pointer, 8'h06);
    run_cycle(1, 0, 0, 0, 0); check_val("halt_hold_ip", instruction_pointer, 8'h06);
    run_cycle(0, 1, 0, 0, 0); check_val("halt_noen", halted, 1);
    run_cycle(1, 1, 0, 0, 0);
    check_val("resume_halted", halted, 0);
    check_val("resume_ip", instruction_pointer, 8'h06);
    run_cycle(1, 0, 0, 0, 0); check_val("resume_next_ip", instruction_pointer, 8'h07);

    do_reset();
    clear_rom();
    rom[8'h00] = enc(5, 0, 0, 0, 0, 0, 8'hFF);
    run_cycle(1, 0, 0, 0, 0);
    run_cycle(1, 0, 0, 0, 0);
    check_val("wrap_ip", instruction_pointer, 0);

`ifdef CPU_SINGLE_STEP_EN
    do_reset();
    clear_rom();
    rom[8'h00] = enc(7, 2, 0, 0, 0, 0, 0);
    run_cycle(1, 0, 0, 0, 0);
    run_cycle(1, 0, 1, 0, 0); check_val("step_ip1", instruction_pointer, 2);
    check_val("step_halted", halted, 1);
    run_cycle(1, 0, 1, 0, 0); check_val("step_ip2", instruction_pointer, 3);
    run_cycle(1, 1, 1, 0, 0);
    check_val("step_resume_halted", halted, 0);
    check_val("step_resume_ip", instruction_pointer, 3);
`endif

    for (int ep = 0; ep < 6; ep++) begin
      do_reset();
      for (int i = 0; i < 256; i++) begin
        int g, t1, t2, a1, a2;
        g = $urandom_range(0, 7);
        if (g == 7 && $urandom_range(0, 3) != 0) g = $urandom_range(0, 6);
        t1 = $urandom_range(0, 1);
        t2 = $urandom_range(0, 1);
        a1 = t1 ? (($urandom_range(0, 3) == 0) ? 255 : $urandom_range(0, 15)) : $urandom_range(0, 255);
        a2 = t2 ? (($urandom_range(0, 3) == 0) ? 255 : $urandom_range(0, 15)) : $urandom_range(0, 255);
        if (g == 2 && t2 == 0) a2 = $urandom_range(0, 9);
        rom[i] = enc(g, $urandom_range(0, 7), t1, a1, t2, a2, $urandom_range(0, 255));
      end
      for (int cyc = 0; cyc < 150; cyc++)
        run_cycle($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 2, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 255), $urandom_range(0, 15));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
